msrv32_integer_file_mp: RTL and testbench
=========================================

MSRV32_INTEGER_FILE_MP -- requirements
Module: msrv32_integer_file_mp

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREGS, default 32, register count, power of two from 2 to 32; AW = clog2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports, 1 to 4.
REQ-004 ms_riscv32_mp_clk_in  input  1  clock; all state updates on the rising edge.
REQ-005 ms_riscv32_mp_rst_in  input  1  reset; asynchronous, active-high.
REQ-006 wr0_en_in / wr0_addr_in / wr0_data_in  input  1/AW/XLEN  primary (ALU) write port.
REQ-007 wr1_en_in / wr1_addr_in / wr1_data_in  input  1/AW/XLEN  secondary (load/long-latency) write port; also clears the scoreboard.
REQ-008 sb_set_en_in / sb_set_addr_in  input  1/AW  marks a register as pending (long-latency op issued).
REQ-009 rs_addr_in  input  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-010 rs_data_out  output  NRD*XLEN  packed read data, combinational.
REQ-011 rs_busy_out  output  NRD  per-port pending flag for the addressed register, combinational.
REQ-012 sb_any_busy_out  output  1  OR of all busy bits, registered view of the scoreboard.

Function
REQ-013 Register 0 SHALL read as zero; writes and scoreboard sets targeting address 0 SHALL be ignored.
REQ-014 A write with wrN_en_in high SHALL update the addressed register on the next rising edge.
REQ-015 Both ports writing the same non-zero address in one cycle: wr0 data SHALL be stored.
REQ-016 Both ports writing different addresses in one cycle: both SHALL be stored.
REQ-017 Each register has one busy bit; sb_set_en_in SHALL set busy[sb_set_addr_in] on the next edge.
REQ-018 wr1_en_in SHALL clear busy[wr1_addr_in] on the next edge; wr0 SHALL NOT affect busy bits.
REQ-019 Set and clear of the same register in one cycle: set SHALL win, so the bit stays 1.
REQ-020 rs_busy_out[k] SHALL equal busy[rs_addr k]; it is 0 for address 0.
REQ-021 sb_any_busy_out SHALL be high when any busy bit is 1, reflecting the state after the last edge.
REQ-022 Read ports SHALL be fully independent; identical addresses on several ports return identical data.
REQ-023 Addresses are AW bits wide, so out-of-range addresses cannot occur; no wrap logic exists.

Reset
REQ-024 While reset is high:
- all registers SHALL be zero;
- all busy bits SHALL be zero;
- rs_data_out, rs_busy_out and sb_any_busy_out SHALL be zero.
REQ-025 Reset asserted mid-operation SHALL discard same-cycle writes and scoreboard sets.
REQ-026 After reset deasserts, the first rising edge SHALL accept writes normally.

Configuration
REQ-027 Macro MSRV32_RF_BYPASS_EN defined, when a port reads a non-zero address being written this cycle:
- rs_data_out SHALL return the write data, using wr0 data if both ports hit;
- if wr1 hits, rs_busy_out SHALL read 0 unless sb_set targets the same address this cycle.
REQ-028 Macro MSRV32_RF_BYPASS_EN undefined: reads SHALL return stored contents and stored busy bits only; new data is visible one cycle after the write edge.

Verification
REQ-029 Reset, then read all addresses on every port -> all data 0, all busy 0, sb_any_busy_out 0.
REQ-030 wr0 x5=0xDEADBEEF, next cycle read x5 on both ports -> 0xDEADBEEF on both; write x0=0x1234 -> x0 reads 0.
REQ-031 Same cycle: wr0 x7=0x11111111 and wr1 x7=0x22222222 -> x7 reads 0x11111111 afterwards.
REQ-032 Scoreboard sequence:
- sb_set x9 -> rs_busy_out 1 and sb_any_busy_out 1;
- wr1 x9=0xA5A5A5A5 -> busy 0, data 0xA5A5A5A5;
- sb_set x9 and wr1 x9 together -> busy stays 1.
REQ-033 Bypass, read x3 while wr0 writes x3=0xCAFEF00D in the same cycle:
- with MSRV32_RF_BYPASS_EN -> 0xCAFEF00D that cycle;
- without it -> old value that cycle, 0xCAFEF00D the next cycle.
REQ-034 Assert reset asynchronously mid-cycle while wr0 x4=0x5 and sb_set x4 are active -> outputs 0 immediately; x4=0 and busy 0 after release.

Source files
------------

// File: rtl/msrv32_integer_file_mp.sv
// Multi-port integer register file with a per-register pending (scoreboard) bit.
// Define MSRV32_RF_BYPASS_EN to forward same-cycle write data/busy-clear onto the read ports.
module msrv32_integer_file_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_in,
    input  logic                wr0_en_in,
    input  logic [AW-1:0]       wr0_addr_in,
    input  logic [XLEN-1:0]     wr0_data_in,
    input  logic                wr1_en_in,
    input  logic [AW-1:0]       wr1_addr_in,
    input  logic [XLEN-1:0]     wr1_data_in,
    input  logic                sb_set_en_in,
    input  logic [AW-1:0]       sb_set_addr_in,
    input  logic [NRD*AW-1:0]   rs_addr_in,
    output logic [NRD*XLEN-1:0] rs_data_out,
    output logic [NRD-1:0]      rs_busy_out,
    output logic                sb_any_busy_out
);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;

    // Entry 0 is never written after reset, so it stays hard zero.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            regs <= '0;
            busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr0_en_in && wr0_addr_in == AW'(i))
                    regs[i] <= wr0_data_in;
                else if (wr1_en_in && wr1_addr_in == AW'(i))
                    regs[i] <= wr1_data_in;

                // A new issue to the same register outranks the completing write.
                if (sb_set_en_in && sb_set_addr_in == AW'(i))
                    busy[i] <= 1'b1;
                else if (wr1_en_in && wr1_addr_in == AW'(i))
                    busy[i] <= 1'b0;
            end
        end
    end

    assign sb_any_busy_out = |busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rs_addr_in[k*AW +: AW];

        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
`ifdef MSRV32_RF_BYPASS_EN
            if (addr != '0) begin
                if (wr1_en_in && wr1_addr_in == addr) begin
                    data = wr1_data_in;
                    if (!(sb_set_en_in && sb_set_addr_in == addr))
                        bsy = 1'b0;
                end
                if (wr0_en_in && wr0_addr_in == addr)
                    data = wr0_data_in;
            end
`endif
            if (ms_riscv32_mp_rst_in) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rs_data_out[k*XLEN +: XLEN] = data;
        assign rs_busy_out[k]              = bsy;
    end

endmodule

// File: tb/tb_msrv32_integer_file_mp.sv
// Directed bench for msrv32_integer_file_mp: a per-cycle model comparison plus literal checks.
module tb_msrv32_integer_file_mp;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr0_en = 1'b0, wr1_en = 1'b0, sb_set = 1'b0;
    logic [AW-1:0]     wr0_addr = '0, wr1_addr = '0, sb_addr = '0;
    logic [XLEN-1:0]   wr0_data = '0, wr1_data = '0;
    logic [NRD*AW-1:0] rs_addr = '0;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]    rs_busy;
    logic              any_busy;

    int errors = 0;
    int checks = 0;

    msrv32_integer_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .wr0_en_in            (wr0_en),
        .wr0_addr_in          (wr0_addr),
        .wr0_data_in          (wr0_data),
        .wr1_en_in            (wr1_en),
        .wr1_addr_in          (wr1_addr),
        .wr1_data_in          (wr1_data),
        .sb_set_en_in         (sb_set),
        .sb_set_addr_in       (sb_addr),
        .rs_addr_in           (rs_addr),
        .rs_data_out          (rs_data),
        .rs_busy_out          (rs_busy),
        .sb_any_busy_out      (any_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // Architectural model: what the register file and scoreboard hold.
    logic [XLEN-1:0] mreg [NREGS];
    logic            mbusy [NREGS];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mreg[i]  <= '0;
                mbusy[i] <= 1'b0;
            end
        end else begin
            if (wr1_en && wr1_addr != 0) mreg[wr1_addr] <= wr1_data;
            if (wr0_en && wr0_addr != 0) mreg[wr0_addr] <= wr0_data;
            if (wr1_en && wr1_addr != 0) mbusy[wr1_addr] <= 1'b0;
            if (sb_set && sb_addr != 0) mbusy[sb_addr] <= 1'b1;
        end
    end

    // Every falling edge: all outputs against the model.
    always @(negedge clk) begin
        logic [XLEN-1:0] ed;
        logic            eb, ea;
        logic [AW-1:0]   a;
        ea = 1'b0;
        for (int i = 0; i < NREGS; i++) ea |= mbusy[i];
        if (rst) ea = 1'b0;
        chk("model_any_busy", {31'b0, any_busy}, {31'b0, ea});
        for (int k = 0; k < NRD; k++) begin
            a  = rs_addr[k*AW +: AW];
            ed = (a == 0) ? '0 : mreg[a];
            eb = (a == 0) ? 1'b0 : mbusy[a];
`ifdef MSRV32_RF_BYPASS_EN
            if (a != 0) begin
                if (wr1_en && wr1_addr == a) begin
                    ed = wr1_data;
                    if (!(sb_set && sb_addr == a)) eb = 1'b0;
                end
                if (wr0_en && wr0_addr == a) ed = wr0_data;
            end
`endif
            if (rst) begin
                ed = '0;
                eb = 1'b0;
            end
            chk("model_rd_data", rs_data[k*XLEN +: XLEN], ed);
            chk("model_rd_busy", {31'b0, rs_busy[k]}, {31'b0, eb});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        sb_set = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rs_addr = {a1, a0};
        #1;
    endtask

    initial begin
        // Reset held: everything reads zero.
        step();
        rd(5'd3, 5'd31);
        chk("rst_data0", rs_data[31:0], 32'h0);
        chk("rst_data1", rs_data[63:32], 32'h0);
        chk("rst_any", {31'b0, any_busy}, 32'h0);
        step();
        rst = 1'b0;

        for (int a = 0; a < NREGS; a++) begin
            rd(AW'(a), AW'(NREGS - 1 - a));
            chk("post_rst_data", rs_data[31:0] | rs_data[63:32], 32'h0);
            chk("post_rst_busy", {30'b0, rs_busy}, 32'h0);
        end
        chk("post_rst_any", {31'b0, any_busy}, 32'h0);

        // Basic write, dual-port read of the same register.
        step();
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        step();
        idle();
        rd(5'd5, 5'd5);
        chk("x5_p0", rs_data[31:0], 32'hDEADBEEF);
        chk("x5_p1", rs_data[63:32], 32'hDEADBEEF);

        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h1234;
        sb_set = 1'b1; sb_addr = 5'd0;
        step();
        idle();
        rd(5'd0, 5'd5);
        chk("x0_zero", rs_data[31:0], 32'h0);
        chk("x0_not_busy", {31'b0, any_busy}, 32'h0);

        // Collision: wr0 wins.
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11111111;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22222222;
        step();
        idle();
        rd(5'd7, 5'd5);
        chk("x7_wr0_wins", rs_data[31:0], 32'h11111111);

        // Different addresses on both ports land together.
        wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'h0000_00C0;
        wr1_en = 1'b1; wr1_addr = 5'd31; wr1_data = 32'hFFFF_0001;
        step();
        idle();
        rd(5'd12, 5'd31);
        chk("x12", rs_data[31:0], 32'h0000_00C0);
        chk("x31", rs_data[63:32], 32'hFFFF_0001);

        // Scoreboard sequence on x9.
        sb_set = 1'b1; sb_addr = 5'd9;
        step();
        idle();
        rd(5'd9, 5'd7);
        chk("x9_busy", {30'b0, rs_busy}, 32'h1);
        chk("x9_any", {31'b0, any_busy}, 32'h1);
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h0BAD0BAD;
        step();
        idle();
        #1;
        chk("x9_wr0_keeps_busy", {30'b0, rs_busy}, 32'h1);
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'hA5A5A5A5;
        step();
        idle();
        #1;
        chk("x9_cleared", {30'b0, rs_busy}, 32'h0);
        chk("x9_data", rs_data[31:0], 32'hA5A5A5A5);
        chk("x9_any_clr", {31'b0, any_busy}, 32'h0);
        sb_set = 1'b1; sb_addr = 5'd9;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h5A5A5A5A;
        step();
        idle();
        #1;
        chk("x9_set_wins", {30'b0, rs_busy}, 32'h1);

        // Same-cycle read of a register being written.
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h00000013;
        step();
        wr0_data = 32'hCAFEF00D;
        rd(5'd3, 5'd3);
`ifdef MSRV32_RF_BYPASS_EN
        chk("x3_same_cycle", rs_data[31:0], 32'hCAFEF00D);
`else
        chk("x3_same_cycle", rs_data[31:0], 32'h00000013);
`endif
        step();
        idle();
        #1;
        chk("x3_next_cycle", rs_data[63:32], 32'hCAFEF00D);

        // Async reset in mid-cycle with a write and a set pending.
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h5;
        sb_set = 1'b1; sb_addr = 5'd4;
        rd(5'd4, 5'd9);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_data0", rs_data[31:0], 32'h0);
        chk("arst_data1", rs_data[63:32], 32'h0);
        chk("arst_busy", {30'b0, rs_busy}, 32'h0);
        chk("arst_any", {31'b0, any_busy}, 32'h0);
        step();
        idle();
        #2;
        rst = 1'b0;
        #1;
        chk("x4_after_rst", rs_data[31:0], 32'h0);
        chk("x9_after_rst", rs_data[63:32], 32'h0);
        chk("busy_after_rst", {30'b0, rs_busy}, 32'h0);

        // First edge after release accepts writes.
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h77;
        sb_set = 1'b1; sb_addr = 5'd10;
        step();
        idle();
        rd(5'd10, 5'd4);
        chk("x10_first_edge", rs_data[31:0], 32'h77);
        chk("x10_busy", {30'b0, rs_busy}, 32'h1);

        // Bypassed completion read (busy view depends on build).
        wr1_en = 1'b1; wr1_addr = 5'd10; wr1_data = 32'h88;
        #1;
        step();
        idle();
        #1;
        chk("x10_done", rs_data[31:0], 32'h88);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
